// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter behind the system bridge.
//
// The CPU stores bytes into a small transmit FIFO. A frame FSM drains the
// FIFO onto txd (LSB first, one start bit, one stop bit). A level interrupt
// signals "transmitter idle and FIFO drained" so software can refill it.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   WE     write strobe, sampled on the rising edge of clk
//   Addr   word address; only Addr[1:0] selects a register
//   Din    write data
//   Dout   read data, combinational from Addr
//   IRQ    registered level interrupt request
//   txd    serial output, idle high
//
// Register map (Addr[1:0]):
//   0 DATA    write pushes Din[7:0]; reads 0
//   1 STATUS  {count[8:4], ovf[3], empty[2], full[1], busy[0]};
//             any write clears ovf
//   2 DIV     baud divisor [15:0], cycles per bit (minimum effective 2)
//   3 CTRL    {ie[1], en[0]}
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [29:0] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Register file
    logic [15:0] div;
    logic        en;
    logic        ie;
    logic        ovf;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // Frame engine
    logic [1:0]  state;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [15:0] cyc_cnt;
    logic [15:0] period;
    logic        cyc_last;
    logic        start_frame;
    logic [15:0] next_period;

    logic [1:0] sel;
    logic       wr_data;
    logic       push;
    logic       pop;
    logic       busy;

    // Only the low address bits decode and Din[31:16] carries nothing.
    logic unused_bits;
    assign unused_bits = ^{Addr[29:2], Din[31:16]};

    assign sel   = Addr[1:0];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign busy  = (state != S_IDLE);

    assign cyc_last    = (cyc_cnt == period - 16'd1);
    assign next_period = (div < 16'd2) ? 16'd2 : div;

    // A new frame starts from IDLE, or straight out of the last STOP cycle so
    // back-to-back frames have no idle gap.
    assign start_frame = en && !empty &&
                         ((state == S_IDLE) || (state == S_STOP && cyc_last));
    assign pop = start_frame;

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign wr_data = WE && (sel == 2'd0);
    assign push    = wr_data && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= Din[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= DIV_RESET;
            en  <= 1'b0;
            ie  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (WE) begin
                case (sel)
                    2'd1:    ovf       <= 1'b0;
                    2'd2:    div       <= Din[15:0];
                    2'd3:    {ie, en}  <= Din[1:0];
                    default: ;
                endcase
            end
            // Dropped push: full and nothing leaving this cycle.
            if (wr_data && full && !pop)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            period  <= 16'd2;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (start_frame) begin
                        state   <= S_START;
                        shift   <= mem[rd_ptr];
                        period  <= next_period;
                        cyc_cnt <= '0;
                        txd     <= 1'b0;
                    end
                end
                S_START: begin
                    if (cyc_last) begin
                        state   <= S_DATA;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        txd     <= shift[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cyc_last) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cyc_last) begin
                        cyc_cnt <= '0;
                        if (start_frame) begin
                            // Period is re-latched here, so a DIV write made
                            // during the previous frame applies from now on.
                            state  <= S_START;
                            shift  <= mem[rd_ptr];
                            period <= next_period;
                            txd    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            IRQ <= 1'b0;
        else
            IRQ <= ie && en && empty && (state == S_IDLE);
    end

    always_comb begin
        Dout = '0;
        case (sel)
            2'd1:    Dout[8:0]  = {5'(count), ovf, empty, full, busy};
            2'd2:    Dout[15:0] = div;
            2'd3:    Dout[1:0]  = {ie, en};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev. A capture process records txd, the
// STATUS busy bit and IRQ every cycle; expected waveforms are built from the
// frame definition (start 0, 8 data bits LSB first, stop 1, each held for
// max(DIV,2) cycles).
module tb_uart_tx_dev;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        WE = 1'b0;
    logic [29:0] Addr = '0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int tests = 0;
    int fails = 0;

    logic cap_en = 1'b0;
    logic txq[$];
    logic bq[$];
    logic iq[$];
    logic exq[$];

    uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
        .clk  (clk),
        .reset(reset),
        .WE   (WE),
        .Addr (Addr),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en) begin
            txq.push_back(txd);
            bq.push_back(Dout[0]);
            iq.push_back(IRQ);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1; Addr = {28'd0, a}; Din = d;
        @(negedge clk);
        WE = 1'b0; Addr = 30'd1; Din = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a};
        #1;
        d = Dout;
    endtask

    task automatic start_cap();
        #1;
        txq.delete(); bq.delete(); iq.delete(); exq.delete();
        Addr = 30'd1;
        cap_en = 1'b1;
    endtask

    task automatic add_frame(input logic [7:0] b, input int p);
        logic v;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      v = 1'b0;
            else if (s == 9) v = 1'b1;
            else             v = b[s-1];
            for (int k = 0; k < p; k++) exq.push_back(v);
        end
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) exq.push_back(1'b1);
    endtask

    // nbusy < 0 skips the busy check (used when writes move Addr during capture).
    task automatic finish_cap(input string tag, input int nbusy);
        int guard = 0;
        int terr = 0;
        int berr = 0;
        while (txq.size() < exq.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        #1 cap_en = 1'b0;
        chk({tag, " length"}, 32'(txq.size() >= exq.size()), 32'd1);
        for (int i = 0; i < exq.size() && i < txq.size(); i++)
            if (txq[i] !== exq[i]) terr++;
        chk({tag, " txd errors"}, 32'(terr), 32'd0);
        if (nbusy >= 0) begin
            for (int i = 0; i < exq.size() && i < bq.size(); i++)
                if (bq[i] !== (i < nbusy)) berr++;
            chk({tag, " busy errors"}, 32'(berr), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b1, b2;
        logic [7:0]  bytes[$];
        int          n, p, ierr;

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(2'd1, d); chk("reset STATUS", d, 32'h04);
        rd(2'd2, d); chk("reset DIV", d, 32'd434);
        rd(2'd3, d); chk("reset CTRL", d, 32'h0);
        rd(2'd0, d); chk("reset DATA read", d, 32'h0);
        chk("reset txd", 32'(txd), 32'd1);
        chk("reset IRQ", 32'(IRQ), 32'd0);

        // Single frame 0xA5 at DIV=4
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'hA5);
        start_cap();
        add_frame(8'hA5, 4); add_idle(5);
        finish_cap("single frame", 40);
        rd(2'd1, d); chk("single STATUS after", d, 32'h04);

        // Back-to-back frames and overflow
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33); wr(2'd0, 32'h44);
        rd(2'd1, d); chk("fifo full STATUS", d, 32'h42);
        wr(2'd0, 32'h55);
        rd(2'd1, d); chk("overflow STATUS", d, 32'h4A);
        wr(2'd3, 32'd1);
        start_cap();
        add_frame(8'h11, 4); add_frame(8'h22, 4); add_frame(8'h33, 4); add_frame(8'h44, 4);
        add_idle(5);
        finish_cap("back-to-back", 160);
        rd(2'd1, d); chk("drained STATUS ovf kept", d, 32'h0C);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, d); chk("ovf cleared", d, 32'h04);

        // Interrupt
        wr(2'd2, 32'd2);
        wr(2'd3, 32'd3);
        chk("irq not yet", 32'(IRQ), 32'd0);
        @(negedge clk);
        chk("irq idle empty", 32'(IRQ), 32'd1);
        wr(2'd0, 32'h7E);
        chk("irq before push effect", 32'(IRQ), 32'd1);
        start_cap();
        add_frame(8'h7E, 2); add_idle(4);
        finish_cap("irq frame", 20);
        ierr = 0;
        for (int i = 0; i < 24 && i < iq.size(); i++)
            if (iq[i] !== (i >= 21)) ierr++;
        chk("irq waveform errors", 32'(ierr), 32'd0);
        wr(2'd3, 32'd1);
        chk("irq before ie clear effect", 32'(IRQ), 32'd1);
        @(negedge clk);
        chk("irq after ie clear", 32'(IRQ), 32'd0);

        // DIV minimum and mid-frame DIV change
        b1 = 8'($urandom); b2 = 8'($urandom);
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd0, {24'd0, b1});
        wr(2'd0, {24'd0, b2});
        wr(2'd3, 32'd1);
        start_cap();
        add_frame(b1, 2); add_frame(b2, 8); add_idle(4);
        repeat (4) @(negedge clk);
        wr(2'd2, 32'd8);
        finish_cap("div change", -1);
        rd(2'd2, d); chk("div readback", d, 32'd8);

        // Randomised frames
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 4);
            p = $urandom_range(2, 6);
            bytes.delete();
            wr(2'd3, 32'd0);
            wr(2'd2, 32'(p));
            for (int k = 0; k < n; k++) begin
                bytes.push_back(8'($urandom));
                wr(2'd0, {24'd0, bytes[k]});
            end
            rd(2'd1, d); chk("random STATUS", d, 32'((n << 4) | ((n == 4) ? 2 : 0)));
            wr(2'd3, 32'd1);
            start_cap();
            for (int k = 0; k < n; k++) add_frame(bytes[k], p);
            add_idle(3);
            finish_cap("random frames", n * 10 * p);
        end

        // Reset mid-frame during data bit 3
        b1 = 8'($urandom) & 8'hF7;
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        wr(2'd0, {24'd0, b1});
        wr(2'd0, 32'h3C);
        repeat (15) @(negedge clk);
        chk("pre-reset txd bit3", 32'(txd), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("reset mid-frame txd", 32'(txd), 32'd1);
        rd(2'd1, d); chk("reset mid-frame STATUS", d, 32'h04);
        @(negedge clk);
        reset = 1'b1;
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        start_cap();
        add_idle(60);
        finish_cap("no residual frame", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter peripheral on the system bridge, a sibling device to the two timer counters.
- Consumes word-aligned store traffic routed by the bridge, serialises bytes as 8N1 frames on a single output pin, and raises a hardware interrupt line that feeds one HWInt bit of the CPU.
- Holds a small transmit FIFO so the CPU can issue several stores without polling.

Parameters:
- FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..16).
- DIV_RESET, 434, reset value of the baud divisor (cycles per bit).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- WE  input  1  write strobe from the bridge, sampled on the rising edge of clk.
- Addr  input  30  word address (byte address [31:2]); only Addr[1:0] is decoded.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr.
- IRQ  output  1  level interrupt request.
- txd  output  1  serial output, idle high.

Behaviour:
- Register map, by Addr[1:0]:
  - 0 DATA: write pushes Din[7:0]; read returns 0.
  - 1 STATUS, read-only except bit3:
    - bit0 busy: the FSM is not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 ovf: sticky; set by a push while full; cleared by any write to STATUS.
    - bits[8:4]: FIFO count.
    - All other bits read 0.
  - 2 DIV: bits[15:0]; upper bits read 0.
  - 3 CTRL: bit0 en, bit1 ie; other bits read 0.
- Reset (reset=0, asynchronous):
  - FIFO empty, count 0; ovf=0; DIV=DIV_RESET; CTRL=0.
  - FSM=IDLE, txd=1, IRQ=0.
  - This applies mid-frame too: txd returns high immediately and no partial frame resumes.
- FIFO behaviour:
  - A push while full is dropped and sets ovf. The FIFO contents are unchanged.
  - A push and a pop in the same cycle are both performed, even when full: the count is unchanged and ovf is not set.
- FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..7 and a cycle counter runs 0..period-1.
- IDLE → START:
  - Condition: en=1 and FIFO non-empty.
  - In the same cycle: pop the head into the shift register and latch period = max(DIV,2).
  - txd=0 from the next cycle.
- START → DATA after period cycles. txd = shift[0]; bits are sent LSB first.
- DATA: shift every period cycles. After 8 bits → STOP.
- STOP: txd=1 for period cycles, then:
  - → START directly (with a pop) if en=1 and FIFO non-empty, so back-to-back frames have no idle gap;
  - else → IDLE.
- Frame length: exactly 10×period cycles.
- A DIV write mid-frame affects only the next frame, because period is latched at START.
- Clearing en mid-frame: the current frame completes, and no new frame starts.
- IRQ = ie & en & empty & (FSM==IDLE), registered so it rises one cycle after the condition becomes true.
  - It deasserts one cycle after a push or after clearing ie or en.
- Writes to CTRL and DIV take effect on the next edge.
- Reads have no side effects.

Test Plan:
- Reset values: release reset → Dout(STATUS)=0x04, Dout(DIV)=434, Dout(CTRL)=0, txd=1, IRQ=0.
- Single frame:
  - Stimulus: DIV=4, CTRL=1, DATA=0xA5.
  - txd sequence per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, 1.
  - busy=1 for 40 cycles, then STATUS=0x04.
- Back-to-back frames:
  - Stimulus: CTRL=0, push 0x11,0x22,0x33,0x44 → STATUS count=4, full=1.
  - Fifth push of 0x55 → ovf=1 and 0x55 is never transmitted.
  - Set CTRL=1 → 4 frames in 160 cycles (DIV=4) with no idle gap between STOP and START.
  - Write STATUS → ovf=0.
- Interrupt:
  - Stimulus: CTRL=3, push 0x7E with DIV=2.
  - IRQ=0 during the frame; IRQ=1 one cycle after return to IDLE.
  - A push deasserts IRQ next cycle; writing CTRL=1 also deasserts IRQ next cycle.
- DIV minimum and mid-frame change:
  - Stimulus: DIV=0 → period=2, so a frame takes 20 cycles.
  - Writing DIV=8 mid-frame leaves the current frame at 20 cycles; the next frame takes 80.
- Reset mid-frame: assert reset during DATA bit 3 → txd=1 and busy=0 immediately; FIFO empty; no residual frame after release.
